map_scroll_timer: RTL and testbench

Parametrised map-scroll timebase for the delivery game: emits one-cycle `move_map` pulses whose period is set by a speed level = automatic base level + player velocity. It replaces the bank of fixed per-speed timers and output mux with a single elapsed-tick counter compared against a computed period. A velocity change therefore never drops a scroll step. It sits between the 1 kHz game tick and the map shifter, and exports the effective level for the velocimeter PWM.

---
 rtl/map_scroll_timer_if.sv | 14 +
 rtl/map_scroll_timer.sv | 69 ++++++
 tb/tb_map_scroll_timer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/map_scroll_timer_if.sv
// map_scroll_timer_if: tick enable, velocity and scroll/level outputs of the map-scroll timebase.
interface map_scroll_timer_if #(
   parameter int VEL_W = 2,
   parameter int LVL_W = 3
);
   logic             count_map;
   logic [VEL_W-1:0] velocity;
   logic             move_map;
   logic [LVL_W-1:0] level;
   logic [LVL_W-1:0] base_level;
   logic             base_max;
   modport master(output count_map, velocity, input move_map, level, base_level, base_max);
   modport slave(input count_map, velocity, output move_map, level, base_level, base_max);
endinterface

// File: rtl/map_scroll_timer.sv
// map_scroll_timer: one elapsed counter compared (>=) against a level-derived period emits move_map pulses.
// Define MAP_SCROLL_RAMP_EN to build the ramp counter that raises base_level automatically.
module map_scroll_timer #(
   parameter int LEVELS      = 8,
   parameter int BASE_PERIOD = 100,
   parameter int PERIOD_STEP = 12,
   parameter int RAMP_TICKS  = 30000,
   parameter int BASE_LEVELS = 4,
   parameter int VEL_W       = 2,
   parameter int CNT_W       = 16,
   parameter int LVL_W       = 3
) (
   input logic clock,
   input logic reset,
   map_scroll_timer_if.slave bus
);
   logic [CNT_W-1:0] elapsed;
   logic [VEL_W-1:0] vel;
   logic [LVL_W-1:0] base_level;
   logic [LVL_W-1:0] lvl;
   logic [LVL_W:0]   sum;
   logic             base_max;
   logic             move_q;
   logic             hit;
   int               per;
   assign vel = bus.velocity;
   assign sum = (LVL_W+1)'(base_level) + (LVL_W+1)'(vel);
   assign lvl = sum > (LVL_W+1)'(LEVELS-1) ? LVL_W'(LEVELS-1) : sum[LVL_W-1:0];
   // Signed period so large levels saturate at 1 instead of wrapping.
   always_comb begin
      per = BASE_PERIOD - PERIOD_STEP * int'(lvl);
      per = per < 1 ? 1 : per;
      hit = int'(elapsed) >= per - 1;
   end
   // >= lets a shrunken period fire on the next enabled edge rather than waiting for wrap-around.
   always_ff @(posedge clock) begin
      if (reset) begin
         elapsed <= '0;
         move_q  <= 1'b0;
      end else begin
         move_q <= bus.count_map && hit;
         if (bus.count_map) elapsed <= hit ? '0 : elapsed + 1'b1;
      end
   end
`ifdef MAP_SCROLL_RAMP_EN
   logic [CNT_W-1:0] ramp;
   assign base_max = base_level == LVL_W'(BASE_LEVELS-1);
   always_ff @(posedge clock) begin
      if (reset) begin
         ramp       <= '0;
         base_level <= '0;
      end else if (bus.count_map) begin
         if (ramp == CNT_W'(RAMP_TICKS-1)) begin
            ramp <= '0;
            if (!base_max) base_level <= base_level + 1'b1;
         end else begin
            ramp <= ramp + 1'b1;
         end
      end
   end
`else
   assign base_level = '0;
   assign base_max   = (BASE_LEVELS == 1) && (RAMP_TICKS > 0);
`endif
   assign bus.move_map   = move_q;
   assign bus.level      = lvl;
   assign bus.base_level = base_level;
   assign bus.base_max   = base_max;
endmodule

// File: tb/tb_map_scroll_timer.sv
// tb_map_scroll_timer: three instances (default, LEVELS=3, RAMP_TICKS=50) against a timestamp-based reference model.
module tb_map_scroll_timer;
`ifdef MAP_SCROLL_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif
   localparam int BL = 4, BP = 100, PS = 12;
   localparam int LV [3] = '{8, 3, 8};
   localparam int RT [3] = '{30000, 30000, 50};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic count_map = 1'b0;
   logic [1:0] vel = 2'd0;
   int checks = 0, failures = 0, cyc = 0;
   int n_en [3], last [3], em [3];
   logic mv [3], bm [3];
   logic [2:0] lvl [3], bse [3];

   always #5 clk = ~clk;

   map_scroll_timer_if ia ();
   map_scroll_timer_if ib ();
   map_scroll_timer_if ic ();
   assign ia.count_map = count_map;
   assign ib.count_map = count_map;
   assign ic.count_map = count_map;
   assign ia.velocity = vel;
   assign ib.velocity = vel;
   assign ic.velocity = vel;
   assign mv[0] = ia.move_map;
   assign mv[1] = ib.move_map;
   assign mv[2] = ic.move_map;
   assign lvl[0] = ia.level;
   assign lvl[1] = ib.level;
   assign lvl[2] = ic.level;
   assign bse[0] = ia.base_level;
   assign bse[1] = ib.base_level;
   assign bse[2] = ic.base_level;
   assign bm[0] = ia.base_max;
   assign bm[1] = ib.base_max;
   assign bm[2] = ic.base_max;

   map_scroll_timer dut_a (.clock(clk), .reset(rst), .bus(ia));
   map_scroll_timer #(.LEVELS(3)) dut_b (.clock(clk), .reset(rst), .bus(ib));
   map_scroll_timer #(.RAMP_TICKS(50)) dut_c (.clock(clk), .reset(rst), .bus(ic));

   function automatic int mbase(int i);
      int b;
      b = n_en[i] / RT[i];
      return RAMP_EN ? (b > BL-1 ? BL-1 : b) : 0;
   endfunction
   function automatic int mlvl(int i, int v);
      int s;
      s = mbase(i) + v;
      return s > LV[i]-1 ? LV[i]-1 : s;
   endfunction
   function automatic int mper(int i, int v);
      int p;
      p = BP - mlvl(i, v) * PS;
      return p < 1 ? 1 : p;
   endfunction

   task automatic chk(input string nm, input int i, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", nm, i, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic cm, input logic [1:0] v);
      int p;
      rst = r;
      count_map = cm;
      vel = v;
      for (int i = 0; i < 3; i++) begin
         if (r) begin
            n_en[i] = 0;
            last[i] = 0;
            em[i] = 0;
         end else if (cm) begin
            p = mper(i, int'(v));
            n_en[i]++;
            em[i] = (n_en[i] - last[i] >= p) ? 1 : 0;
            if (em[i] == 1) last[i] = n_en[i];
         end else begin
            em[i] = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         chk("move_map", i, int'(mv[i]), em[i]);
         chk("level", i, int'(lvl[i]), mlvl(i, int'(v)));
         chk("base_level", i, int'(bse[i]), mbase(i));
         chk("base_max", i, int'(bm[i]), (RAMP_EN && mbase(i) == BL-1) ? 1 : 0);
      end
   endtask

   typedef struct {
      logic [1:0] v;
      int lvl_a;
      int lvl_b;
   } vec_t;
   vec_t tbl [4];

   initial begin
      int pc, first;
      tbl[0] = '{2'd0, 0, 0};
      tbl[1] = '{2'd1, 1, 1};
      tbl[2] = '{2'd2, 2, 2};
      tbl[3] = '{2'd3, 3, 2};
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, tbl[k].v);
         chk("tbl_level_a", 0, int'(lvl[0]), tbl[k].lvl_a);
         chk("tbl_level_b", 1, int'(lvl[1]), tbl[k].lvl_b);
         chk("tbl_move", 0, int'(mv[0]), 0);
      end
      // steady scroll at level 0
      step(1'b1, 1'b0, 2'd0);
      pc = 0;
      for (int e = 1; e <= 350; e++) begin
         step(1'b0, 1'b1, 2'd0);
         if (mv[0]) begin
            pc++;
            chk("pulse_edge", 0, e, 100 * pc);
         end
      end
      chk("pulse_count", 0, pc, 3);
      // velocity jump after the period has already been passed
      step(1'b1, 1'b0, 2'd0);
      for (int e = 1; e <= 80; e++) step(1'b0, 1'b1, 2'd0);
      step(1'b0, 1'b1, 2'd3);
      chk("vel_jump_pulse", 0, int'(mv[0]), 1);
      pc = 0;
      for (int e = 1; e <= 64; e++) begin
         step(1'b0, 1'b1, 2'd3);
         pc += int'(mv[0]);
      end
      chk("vel_jump_next", 0, int'(mv[0]), 1);
      chk("vel_jump_count", 0, pc, 1);
      // freeze mid-interval
      step(1'b1, 1'b0, 2'd0);
      for (int e = 1; e <= 50; e++) step(1'b0, 1'b1, 2'd0);
      pc = 0;
      for (int e = 1; e <= 40; e++) begin
         step(1'b0, 1'b0, 2'd0);
         pc += int'(mv[0]);
      end
      chk("frozen_pulses", 0, pc, 0);
      first = 0;
      for (int e = 1; e <= 60; e++) begin
         step(1'b0, 1'b1, 2'd0);
         if (mv[0] && first == 0) first = e;
      end
      chk("resume_edge", 0, first, 50);
      // clamped level on the 3-level instance gives period 76
      step(1'b1, 1'b0, 2'd3);
      first = 0;
      for (int e = 1; e <= 80; e++) begin
         step(1'b0, 1'b1, 2'd3);
         if (mv[1] && first == 0) first = e;
      end
      chk("clamp_period", 1, first, 76);
      // base-level ramp on the fast-ramp instance
      step(1'b1, 1'b0, 2'd0);
      for (int e = 1; e <= 250; e++) begin
         step(1'b0, 1'b1, 2'd0);
         if (e == 49) chk("ramp_49", 2, int'(bse[2]), 0);
         if (e == 50) chk("ramp_50", 2, int'(bse[2]), RAMP_EN ? 1 : 0);
         if (e == 100) chk("ramp_100", 2, int'(bse[2]), RAMP_EN ? 2 : 0);
         if (e == 149) chk("bmax_149", 2, int'(bm[2]), 0);
         if (e == 150) chk("bmax_150", 2, int'(bm[2]), RAMP_EN ? 1 : 0);
         if (e == 250) chk("ramp_250", 2, int'(bse[2]), RAMP_EN ? 3 : 0);
      end
      // reset while a pulse is high
      first = 0;
      for (int e = 1; e <= 200 && first == 0; e++) begin
         step(1'b0, 1'b1, 2'd0);
         if (mv[0]) first = e;
      end
      chk("found_pulse", 0, int'(first != 0), 1);
      step(1'b1, 1'b1, 2'd0);
      chk("reset_drop", 0, int'(mv[0]), 0);
      // randomized traffic
      for (int k = 0; k < 4000; k++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
